// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit.
// Condition codes, predictor reset value and PC step.
package branch_resolve_unit_pkg;

  localparam logic [2:0] COND_NONE = 3'd0;
  localparam logic [2:0] COND_JUMP = 3'd1;
  localparam logic [2:0] COND_BEZ  = 3'd2;
  localparam logic [2:0] COND_BNE  = 3'd3;
  localparam logic [2:0] COND_BEQ  = 3'd4;
  localparam logic [2:0] COND_BLTZ = 3'd5;
  localparam logic [2:0] COND_BGEZ = 3'd6;
  localparam logic [2:0] COND_BGTZ = 3'd7;

  localparam logic [1:0] BHT_RST_VAL = 2'b01;
  localparam int unsigned PC_INC = 4;

  function automatic logic is_cond_branch(
    input logic [2:0] cmd
  );
    return (cmd != COND_NONE) &&
           (cmd != COND_JUMP);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// IF/ID-side bus of the branch resolve unit.
// master: pipeline side, slave: resolve unit.
interface branch_resolve_unit_if #(
  parameter int WORD_LEN = 32,
  parameter int CNT_W    = 16
);
  logic [WORD_LEN-1:0] IF_PC;
  logic                PREDICT_TAKEN;
  logic                ID_VALID;
  logic                STALL;
  logic                FLUSH;
  logic [WORD_LEN-1:0] ID_PC;
  logic [WORD_LEN-1:0] REGISTER1;
  logic [WORD_LEN-1:0] REGISTER2;
  logic [2:0]          BRANCH_COMMAND;
  logic [WORD_LEN-1:0] BRANCH_TARGET;
  logic                ID_PRED_TAKEN;
  logic                RESOLVE_VALID;
  logic                BRANCH_CONDITION;
  logic                MISPREDICT;
  logic [WORD_LEN-1:0] REDIRECT_PC;
  logic [CNT_W-1:0]    BRANCH_COUNT;
  logic [CNT_W-1:0]    MISPREDICT_COUNT;

  modport master (
    output IF_PC, ID_VALID, STALL, FLUSH,
    output ID_PC, REGISTER1, REGISTER2,
    output BRANCH_COMMAND, BRANCH_TARGET,
    output ID_PRED_TAKEN,
    input  PREDICT_TAKEN, RESOLVE_VALID,
    input  BRANCH_CONDITION, MISPREDICT,
    input  REDIRECT_PC, BRANCH_COUNT,
    input  MISPREDICT_COUNT
  );

  modport slave (
    input  IF_PC, ID_VALID, STALL, FLUSH,
    input  ID_PC, REGISTER1, REGISTER2,
    input  BRANCH_COMMAND, BRANCH_TARGET,
    input  ID_PRED_TAKEN,
    output PREDICT_TAKEN, RESOLVE_VALID,
    output BRANCH_CONDITION, MISPREDICT,
    output REDIRECT_PC, BRANCH_COUNT,
    output MISPREDICT_COUNT
  );
endinterface

// File: rtl/bht_counter_table.sv
// 2-bit saturating counter table; async read, sync update.
// Ports: rd_idx/rd_cnt read, wr_en/wr_idx/wr_taken update.
module bht_counter_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] cnt_q [DEPTH];

  assign rd_cnt = cnt_q[rd_idx];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++)
        cnt_q[i] <= BHT_RST_VAL;
    end else if (wr_en) begin
      if (wr_taken) begin
        if (cnt_q[wr_idx] != 2'b11)
          cnt_q[wr_idx] <= cnt_q[wr_idx] + 2'd1;
      end else begin
        if (cnt_q[wr_idx] != 2'b00)
          cnt_q[wr_idx] <= cnt_q[wr_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves ID-stage branches, trains the BHT, flags mispredicts.
// Ports: CLK, RST_N, bus (slave side of branch_resolve_unit_if).
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int WORD_LEN  = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
  input logic CLK,
  input logic RST_N,
  branch_resolve_unit_if.slave bus
);

  logic [WORD_LEN-1:0] r1, r2;
  logic [2:0]          cmd;
  logic                taken;
  logic                resolve;
  logic                cond_br;
  logic [1:0]          rd_cnt;

  logic                rv_q, bc_q, mp_q;
  logic [WORD_LEN-1:0] rpc_q;
  logic [CNT_W-1:0]    bcnt_q, mcnt_q;

  assign r1  = bus.REGISTER1;
  assign r2  = bus.REGISTER2;
  assign cmd = bus.BRANCH_COMMAND;

  always_comb begin
    taken = 1'b0;
    unique case (cmd)
      COND_NONE: taken = 1'b0;
      COND_JUMP: taken = 1'b1;
      COND_BEZ:  taken = (r1 == '0);
      COND_BNE:  taken = (r1 != r2);
      COND_BEQ:  taken = (r1 == r2);
      COND_BLTZ: taken = ($signed(r1) < 0);
      COND_BGEZ: taken = ($signed(r1) >= 0);
      COND_BGTZ: taken = ($signed(r1) > 0);
      default:   taken = 1'b0;
    endcase
  end

  assign resolve = bus.ID_VALID & ~bus.STALL &
                   ~bus.FLUSH & (cmd != COND_NONE);
  assign cond_br = resolve & is_cond_branch(cmd);

  bht_counter_table #(
    .DEPTH (BHT_DEPTH)
  ) u_bht (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .rd_idx   (bus.IF_PC[IDX_W+1:2]),
    .rd_cnt   (rd_cnt),
    .wr_en    (cond_br),
    .wr_idx   (bus.ID_PC[IDX_W+1:2]),
    .wr_taken (taken)
  );

  assign bus.PREDICT_TAKEN = rd_cnt[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rv_q   <= 1'b0;
      bc_q   <= 1'b0;
      mp_q   <= 1'b0;
      rpc_q  <= '0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else if (!bus.STALL) begin
      rv_q <= resolve;
      bc_q <= resolve & taken;
      mp_q <= resolve & (taken != bus.ID_PRED_TAKEN);
      if (resolve)
        rpc_q <= taken ? bus.BRANCH_TARGET
                       : bus.ID_PC + WORD_LEN'(PC_INC);
      if (cond_br && bcnt_q != '1)
        bcnt_q <= bcnt_q + 1'b1;
      if (resolve && taken != bus.ID_PRED_TAKEN
          && mcnt_q != '1)
        mcnt_q <= mcnt_q + 1'b1;
    end
  end

  assign bus.RESOLVE_VALID    = rv_q;
  assign bus.BRANCH_CONDITION = bc_q;
  assign bus.MISPREDICT       = mp_q;
  assign bus.REDIRECT_PC      = rpc_q;
  assign bus.BRANCH_COUNT     = bcnt_q;
  assign bus.MISPREDICT_COUNT = mcnt_q;

  logic unused_ok;
  assign unused_ok = ^{1'b0, rd_cnt[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit.
// Reference model: integer BHT array and counters.
module tb_branch_resolve_unit;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  branch_resolve_unit_if #(.WORD_LEN(32), .CNT_W(16)) bus ();

  branch_resolve_unit #(
    .WORD_LEN(32), .BHT_DEPTH(16), .CNT_W(16)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  int          bht_m [16];
  int          bcnt_m, mcnt_m;
  bit          rv_m, bc_m, mp_m;
  logic [31:0] rpc_m;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  function automatic void model_reset();
    foreach (bht_m[i]) bht_m[i] = 1;
    bcnt_m = 0; mcnt_m = 0;
    rv_m = 0; bc_m = 0; mp_m = 0; rpc_m = 0;
  endfunction

  function automatic bit model_taken(int cmd, int a, int b);
    case (cmd)
      0: return 0;
      1: return 1;
      2: return a == 0;
      3: return a != b;
      4: return a == b;
      5: return a < 0;
      6: return a >= 0;
      default: return a > 0;
    endcase
  endfunction

  task automatic check_outs(string tag);
    chk({tag, ".rv"},   bus.RESOLVE_VALID, rv_m);
    chk({tag, ".cond"}, bus.BRANCH_CONDITION, bc_m);
    chk({tag, ".mp"},   bus.MISPREDICT, mp_m);
    chk({tag, ".rpc"},  bus.REDIRECT_PC, rpc_m);
    chk({tag, ".bcnt"}, bus.BRANCH_COUNT, bcnt_m);
    chk({tag, ".mcnt"}, bus.MISPREDICT_COUNT, mcnt_m);
  endtask

  // Called just after a posedge; applies inputs for the next edge.
  task automatic drive(string tag, bit v, bit st, bit fl,
                       logic [2:0] cmd, logic [31:0] a,
                       logic [31:0] b, logic [31:0] pc,
                       logic [31:0] tgt, bit pr,
                       logic [31:0] ifpc);
    bit t;
    int i;
    bus.ID_VALID = v; bus.STALL = st; bus.FLUSH = fl;
    bus.BRANCH_COMMAND = cmd;
    bus.REGISTER1 = a; bus.REGISTER2 = b;
    bus.ID_PC = pc; bus.BRANCH_TARGET = tgt;
    bus.ID_PRED_TAKEN = pr; bus.IF_PC = ifpc;
    #1;
    chk({tag, ".pred"}, bus.PREDICT_TAKEN, bht_m[ifpc[5:2]] >= 2);
    @(posedge CLK);
    if (!st) begin
      if (v && !fl && cmd != 0) begin
        t = model_taken(int'(cmd), a, b);
        rv_m = 1; bc_m = t; mp_m = (t != pr);
        rpc_m = t ? tgt : pc + 32'd4;
        if (cmd >= 2) begin
          i = int'(pc[5:2]);
          bht_m[i] = t ? ((bht_m[i] < 3) ? bht_m[i] + 1 : 3)
                       : ((bht_m[i] > 0) ? bht_m[i] - 1 : 0);
          if (bcnt_m < 65535) bcnt_m++;
        end
        if (mp_m && mcnt_m < 65535) mcnt_m++;
      end else begin
        rv_m = 0; bc_m = 0; mp_m = 0;
      end
    end
    #1;
    check_outs(tag);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b, pc;
    model_reset();
    bus.ID_VALID = 0; bus.STALL = 0; bus.FLUSH = 0;
    bus.BRANCH_COMMAND = 0; bus.REGISTER1 = 0;
    bus.REGISTER2 = 0; bus.ID_PC = 0;
    bus.BRANCH_TARGET = 0; bus.ID_PRED_TAKEN = 0;
    bus.IF_PC = 32'h40;
    repeat (2) @(posedge CLK);
    #1;
    check_outs("reset");
    chk("reset.pred", bus.PREDICT_TAKEN, 1'b0);
    RST_N = 1'b1;

    // BNE taken, predicted not-taken
    drive("bne", 1, 0, 0, 3'd3, 5, 7, 32'h40, 32'h100, 0, 32'h40);
    chk("bne.rpc_abs", bus.REDIRECT_PC, 32'h100);
    chk("bne.pred_now", bus.PREDICT_TAKEN, 1'b1);

    // signed boundaries
    drive("bltz", 1, 0, 0, 3'd5, 32'h8000_0000, 0,
          32'h10, 32'h200, 0, 32'h10);
    chk("bltz.abs", bus.BRANCH_CONDITION, 1'b1);
    drive("bgtz", 1, 0, 0, 3'd7, 0, 0, 32'h10, 32'h200, 1, 32'h10);
    chk("bgtz.rpc_abs", bus.REDIRECT_PC, 32'h14);
    drive("bgez", 1, 0, 0, 3'd6, 0, 0, 32'h10, 32'h200, 0, 32'h10);

    // saturation both ways
    repeat (5)
      drive("sat_up", 1, 0, 0, 3'd4, 3, 3, 32'h80, 32'h300, 1, 32'h80);
    repeat (5)
      drive("sat_dn", 1, 0, 0, 3'd4, 3, 4, 32'h80, 32'h300, 0, 32'h80);
    drive("sat_chk", 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h80);

    // stall then flush with a live resolve
    drive("pre", 1, 0, 0, 3'd3, 1, 2, 32'h20, 32'h400, 1, 32'h20);
    drive("stall", 1, 1, 0, 3'd3, 1, 1, 32'h24, 32'h500, 1, 32'h24);
    drive("stall2", 1, 1, 1, 3'd3, 1, 2, 32'h24, 32'h500, 0, 32'h24);
    drive("flush", 1, 0, 1, 3'd3, 1, 2, 32'h24, 32'h500, 0, 32'h24);

    // jump then async reset between edges
    drive("jump", 1, 0, 0, 3'd1, 0, 0, 32'h40, 32'h600, 0, 32'h40);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    bus.IF_PC = 32'h40;
    #1;
    chk("async_rst.pred", bus.PREDICT_TAKEN, 1'b0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    drive("post_rst", 1, 0, 0, 3'd2, 0, 0, 32'h40, 32'h700, 1, 32'h40);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      a = rnd_op();
      b = ($urandom_range(0, 3) == 0) ? a : rnd_op();
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                         : {$urandom_range(0, 63), 2'b00};
      drive("rnd", $urandom_range(0, 7) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            3'($urandom_range(0, 7)), a, b, pc, $urandom,
            1'($urandom_range(0, 1)),
            {$urandom_range(0, 63), 2'b00});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor to the single-cycle branch condition checker. Evaluates an extended MIPS branch-condition set on ID-stage operands and registers the result. Keeps a per-PC table of 2-bit saturating counters; IF reads it for predictions and ID-stage resolves update it. Reports mispredictions with a redirect PC and keeps saturating performance counters. Sits between the ID stage and the IF PC-select logic.

Parameters:
WORD_LEN, 32, operand and PC width in bits.
BHT_DEPTH, 16, number of predictor entries; power of two, minimum 2.
CNT_W, 16, width of the performance counters.

Ports:
CLK  in  1  rising-edge clock.
RST_N  in  1  asynchronous active-low reset.
IF_PC  in  WORD_LEN  fetch PC used for prediction lookup.
PREDICT_TAKEN  out  1  combinational prediction: MSB of BHT[IF_PC index].
ID_VALID  in  1  ID-stage instruction valid.
STALL  in  1  ID stall; holds all state and outputs.
FLUSH  in  1  squashes the ID-stage instruction this cycle.
ID_PC  in  WORD_LEN  PC of the ID-stage instruction.
REGISTER1, REGISTER2  in  WORD_LEN  operands (rs, rt).
BRANCH_COMMAND  in  3  condition encoding, defined in the package.
BRANCH_TARGET  in  WORD_LEN  computed taken target.
ID_PRED_TAKEN  in  1  prediction carried down the pipeline with the instruction.
RESOLVE_VALID  out  1  registered: a branch or jump resolved last cycle.
BRANCH_CONDITION  out  1  registered actual taken outcome.
MISPREDICT  out  1  registered: actual outcome differs from ID_PRED_TAKEN.
REDIRECT_PC  out  WORD_LEN  registered correct next PC.
BRANCH_COUNT  out  CNT_W  resolved conditional branches, saturating.
MISPREDICT_COUNT  out  CNT_W  mispredicted resolves, saturating.

Behaviour:
- Reset (RST_N low, asynchronous): all registered outputs 0. All BHT entries reset to 2'b01 (weakly not-taken). Both counters reset to 0.
- Index: ID_PC[IDX_W+1:2] and IF_PC[IDX_W+1:2], where IDX_W = log2(BHT_DEPTH).
- Command conditions; all comparisons signed two's complement:
  - NONE: not taken.
  - JUMP: always taken.
  - BEZ: R1 == 0.
  - BNE: R1 != R2.
  - BEQ: R1 == R2.
  - BLTZ: R1 < 0.
  - BGEZ: R1 >= 0.
  - BGTZ: R1 > 0.
- Resolve event: ID_VALID & !STALL & !FLUSH & command != NONE.
- Latency is one cycle. On the edge after a resolve event:
  - RESOLVE_VALID = 1.
  - BRANCH_CONDITION = actual outcome.
  - MISPREDICT = actual != ID_PRED_TAKEN.
  - REDIRECT_PC = actual ? BRANCH_TARGET : ID_PC + 4, with modulo-2^WORD_LEN wrap.
- On a non-event cycle that is not stalled: RESOLVE_VALID, BRANCH_CONDITION and MISPREDICT clear to 0; REDIRECT_PC holds its value.
- STALL high: every register holds. STALL has priority over FLUSH for state-holding, and a stalled cycle is never a resolve event.
- BHT update on conditional branches only (not JUMP, not NONE), on the same edge as the resolve:
  - Taken: increment, saturating at 3.
  - Not taken: decrement, saturating at 0.
- JUMP: does not update the BHT or BRANCH_COUNT. Its MISPREDICT is still computed.
- PREDICT_TAKEN is a pure read. If the lookup and update hit the same index in the same cycle, the read returns the pre-update value (no bypass).
- Counters:
  - BRANCH_COUNT increments per conditional resolve.
  - MISPREDICT_COUNT increments per resolve with a mispredict, including JUMP.
  - Both hold at all-ones.
- Reset asserted mid-operation clears everything within the same cycle, independent of the clock. The first resolve after RST_N deasserts uses the reset BHT state.

Decomposition:
- Shared package/defines: the 3-bit command codes COND_NONE=0, COND_JUMP=1, COND_BEZ=2, COND_BNE=3, COND_BEQ=4, COND_BLTZ=5, COND_BGEZ=6, COND_BGTZ=7. Also the BHT reset value 2'b01 and the PC increment of 4.
- Sub-module `bht_counter_table`: BHT_DEPTH x 2-bit array with one asynchronous read port, one synchronous update port (index, taken, enable) and asynchronous active-low reset.
- Condition evaluation stays in the top level as a combinational case.

Test Plan:
1. Reset, then IF_PC=0x40 -> PREDICT_TAKEN=0. All outputs 0 and both counters 0.
2. BNE, R1=5, R2=7, ID_PRED_TAKEN=0, target 0x100, ID_PC=0x40 -> next cycle BRANCH_CONDITION=1, MISPREDICT=1, REDIRECT_PC=0x100. BHT[0x40 index]=2'b10 and PREDICT_TAKEN for 0x40 is now 1. BRANCH_COUNT=1, MISPREDICT_COUNT=1.
3. Signed boundaries with ID_PC=0x10:
   - BLTZ R1=0x80000000 -> taken.
   - BGTZ R1=0 -> not taken, REDIRECT_PC=0x14.
   - BGEZ R1=0 -> taken.
4. Same BEQ-taken at one PC 5 times -> counter saturates at 3. Then 4 not-taken -> saturates at 0, with no wrap in either direction.
5. Resolve asserted with STALL=1 -> outputs and BHT unchanged. Same inputs with FLUSH=1 -> RESOLVE_VALID=0 and no BHT or counter change.
6. JUMP with ID_PRED_TAKEN=0 -> MISPREDICT=1, MISPREDICT_COUNT increments, BRANCH_COUNT and BHT unchanged. Then assert RST_N low between clock edges -> outputs clear immediately.
